// File: rtl/ifetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns PC, link register, next-PC selection, stall hold, wrong-path flush
// and a sticky stall watchdog.
module ifetch_stage #(
  parameter int unsigned    AW        = 8,
  parameter int unsigned    IW        = 8,
  parameter logic [IW-1:0]  NOP_INS   = 8'h00,
  parameter logic [AW-1:0]  RESET_PC  = 8'h00,
  parameter int unsigned    STALL_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_en,
  input  logic [1:0]    pc_sec,
  input  logic [AW-1:0] br_target,
  input  logic          lr_we,
  input  logic [AW-1:0] lr_din,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] id_ins,
  output logic [AW-1:0] id_pc1,
  output logic          id_valid,
  output logic          kill_id,
  output logic [AW-1:0] lr_out,
  output logic          stall_err
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_SAT = '1;

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus1;
  logic [CW-1:0] stall_cnt;
  logic          redirect;

  logic [AW-1:0] pc_n;
  logic [IW-1:0] ins_n;
  logic [AW-1:0] pc1_n;
  logic          valid_n;
  logic [AW-1:0] lr_n;
  logic [CW-1:0] cnt_n;
  logic          err_n;

  assign pc_plus1  = pc + AW'(1);
  assign imem_addr = pc;

  // Only 01 (branch) and 10 (return) redirect; 11 behaves as sequential.
  assign redirect = (pc_sec == 2'b01) || (pc_sec == 2'b10);
  assign kill_id  = redirect;

  // Next-state selection: redirect beats stall beats advance.
  always_comb begin
    pc_n    = pc;
    ins_n   = id_ins;
    pc1_n   = id_pc1;
    valid_n = id_valid;
    cnt_n   = stall_cnt;
    err_n   = stall_err;
    lr_n    = lr_we ? lr_din : lr_out;

    if (redirect) begin
      // Return reads the link register before any same-cycle write lands.
      pc_n    = (pc_sec == 2'b01) ? br_target : lr_out;
      ins_n   = NOP_INS;
      pc1_n   = '0;
      valid_n = 1'b0;
      cnt_n   = '0;
    end else if (!pc_en) begin
      cnt_n = (stall_cnt == CNT_SAT) ? stall_cnt : stall_cnt + CW'(1);
      if (cnt_n >= CW'(STALL_MAX)) begin
        err_n = 1'b1;
      end
    end else begin
      pc_n    = pc_plus1;
      ins_n   = imem_data;
      pc1_n   = pc_plus1;
      valid_n = 1'b1;
      cnt_n   = '0;
    end
  end

  // Fetch-stage state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      id_ins    <= NOP_INS;
      id_pc1    <= '0;
      id_valid  <= 1'b0;
      lr_out    <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      pc        <= pc_n;
      id_ins    <= ins_n;
      id_pc1    <= pc1_n;
      id_valid  <= valid_n;
      lr_out    <= lr_n;
      stall_cnt <= cnt_n;
      stall_err <= err_n;
    end
  end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 8-bit pipelined CPU, directly upstream of decode, branch control and bubble control. Owns the program counter, the link register, next-PC selection (sequential / branch / return), stall hold and wrong-path flush. Presents the fetched instruction plus its PC+1 to the decode stage.

Parameters:
AW, 8, address/PC width.
IW, 8, instruction width.
NOP_INS, 8'h00, instruction injected into IF/ID on flush/reset (opcode 0 = no-op).
RESET_PC, 8'h00, PC value after reset.
STALL_MAX, 15, consecutive stall cycles tolerated before stall_err sets (1..255).

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  reset, asynchronous, active-low.
pc_en  in  1  1 = advance, 0 = stall (load-use bubble), sampled on posedge.
pc_sec  in  2  next-PC select from EXE: 00 sequential, 01 branch target, 10 return via LR, 11 reserved.
br_target  in  AW  branch/subroutine target from EXE.
lr_we  in  1  link-register write enable (BR.SUB in EXE).
lr_din  in  AW  return address to store (PC+1 of the BR.SUB).
imem_addr  out  AW  instruction memory address (asynchronous-read ROM).
imem_data  in  IW  instruction at imem_addr, same cycle.
id_ins  out  IW  IF/ID instruction register.
id_pc1  out  AW  PC+1 of id_ins.
id_valid  out  1  id_ins is a real fetched instruction.
kill_id  out  1  combinational flush request to ID/EX register.
lr_out  out  AW  current link register value.
stall_err  out  1  sticky stall-watchdog flag.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, id_ins=NOP_INS, id_pc1=0, id_valid=0, lr=0, stall counter=0, stall_err=0. kill_id then follows inputs only.
- imem_addr = pc (combinational); fetched instruction registered into IF/ID at the next posedge: 1-cycle fetch latency.
- redirect = (pc_sec==01) or (pc_sec==10); kill_id = redirect, combinational.
- Per posedge, priority: redirect > stall > advance.
  - Redirect: pc <= br_target (01) or lr (10); id_ins <= NOP_INS, id_valid <= 0, id_pc1 <= 0. Redirect overrides pc_en=0.
  - Stall (pc_en=0, no redirect): pc, id_ins, id_pc1, id_valid hold.
  - Advance: pc <= pc+1; id_ins <= imem_data; id_pc1 <= pc+1; id_valid <= 1.
- pc_sec=11: treated as 00; no flush, kill_id=0.
- Arithmetic: pc+1 modulo 2^AW; 8'hFF wraps to 8'h00 with no flag.
- LR: lr <= lr_din on posedge when lr_we=1, independent of stall. lr_we and pc_sec=10 in the same cycle: return uses the old lr value (read before write).
- Stall watchdog: counter increments on each posedge with pc_en=0 and no redirect, saturating at 255. It clears on any advance or redirect. When the count reaches STALL_MAX, stall_err sets and stays set until reset.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately. First fetch after release is from RESET_PC.

Test Plan:
- Reset then 4 free-running cycles with ROM[i]=8'h10+i, pc_en=1 -> id_ins = 10,11,12,13; id_pc1 = 1,2,3,4; id_valid=1 from first edge; imem_addr = 4.
- Stall at pc=5 held 2 cycles (pc_en=0) -> pc stays 5, id_ins/id_pc1 frozen, stall_err=0; resumes with ROM[5] on the next advance.
- pc_sec=01, br_target=8'h40, with pc_en=0 in the same cycle -> kill_id=1 that cycle; next edge pc=40, id_ins=00, id_valid=0; following edge id_ins=ROM[40].
- BR.SUB: lr_we=1, lr_din=8'h21, pc_sec=01, target 8'h80. Later pc_sec=10 -> pc=21, IF/ID flushed. A repeat with lr_we=1, lr_din=8'h55 in the return cycle -> pc=21 (old lr), lr_out=55 afterwards.
- Run from pc=8'hFE -> pc sequence FE, FF, 00; id_pc1 for the FF instruction = 00.
- pc_en=0 held for 15 cycles (STALL_MAX=15) -> stall_err=1 at the 15th edge. It stays 1 after pc_en returns to 1 and clears only on rst=0.
